nios2_mul_combine: RTL

- Downstream consumer of the 3-cell 16x16 partial-product multiplier.
- Inputs: registered partial products p1 (lo×lo), p2 (src1 lo × src2 hi), p3 (src1 hi × src2 lo).
- Output: the 32-bit MUL result via a 2-stage elastic pipeline with valid/ready handshake, destination-tag passthrough and pipeline flush.
- Sits between the M-stage multiplier cells and the writeback mux.

---
 rtl/nios2_mul_combine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/nios2_mul_combine.sv
// ---------------------------------------------------------------------------
// nios2_mul_combine
//
// Combines the registered 16x16 partial products from the M-stage multiplier
// cells into the 32-bit MUL result. There are two elastic stages with a
// valid/ready handshake, the destination tag travels with each operation,
// and a synchronous flush drops everything in flight.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high. A producer holds valid and its data stable until ready.
// in_ready is combinational from out_ready, so a full pipeline streams one
// result per cycle with no bubble.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_p1, in_p2, in_p3   lo*lo, src1lo*src2hi and src1hi*src2lo partials
//   in_tag                destination-register tag (TAG_W bits)
//   flush                 drop all in-flight operations
//   out_valid / out_ready output handshake
//   out_result, out_tag   low 32 bits of the product and its tag
//
// Optional build macro NIOS2_MUL_COMBINE_HIGH_EN adds:
//   in_p4                 src1hi*src2hi partial
//   out_result_hi         upper 32 bits of the product (MULXUU)
// ---------------------------------------------------------------------------
module nios2_mul_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
    input  logic [31:0]      in_p4,
`endif
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
    output logic [31:0]      out_result_hi,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // Without the high word only the low 16 bits of the middle sum ever
    // reach the result, so the middle adder and register shrink to 16 bits.
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
    localparam int MID_W = 33;
`else
    localparam int MID_W = 16;
`endif

    // Each stage is a two-state occupancy machine. Both live in one struct
    // so the whole pipeline state is visible as a single signal.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    typedef struct packed {
        stage_state_e s1;
        stage_state_e s2;
    } pipe_state_t;

    pipe_state_t      state_q, state_d;

    logic [31:0]      s1_p1_q, s1_p1_d;
    logic [MID_W-1:0] s1_mid_q, s1_mid_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
    logic [31:0]      s1_p4_q, s1_p4_d;
    logic [31:0]      out_result_hi_q, out_result_hi_d;
    logic [32:0]      lo_sum;
`endif

    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic s1_adv;
    logic s1_load;
    logic s2_load;

    assign s1_valid = (state_q.s1 == ST_FULL);
    assign s2_valid = (state_q.s2 == ST_FULL);

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // An input offered during flush is dropped even when in_ready is high.
    assign s1_load  = in_valid & s1_adv & ~flush;
    // S2 may still pick up S1 data during flush; its valid is cleared anyway.
    assign s2_load  = s1_valid & s2_adv;

    always_comb begin
        state_d         = state_q;
        s1_p1_d         = s1_p1_q;
        s1_mid_d        = s1_mid_q;
        s1_tag_d        = s1_tag_q;
        out_result_d    = out_result_q;
        out_tag_d       = out_tag_q;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
        s1_p4_d         = s1_p4_q;
        out_result_hi_d = out_result_hi_q;
        lo_sum          = {1'b0, s1_p1_q} + {1'b0, s1_mid_q[15:0], 16'h0};
`endif

        if (flush) begin
            state_d.s1 = ST_EMPTY;
            state_d.s2 = ST_EMPTY;
        end else begin
            case (state_q.s1)
                ST_EMPTY: if (s1_load) state_d.s1 = ST_FULL;
                ST_FULL: begin
                    // Drain and refill in the same cycle keeps it FULL.
                    if (s1_load)      state_d.s1 = ST_FULL;
                    else if (s2_load) state_d.s1 = ST_EMPTY;
                end
                default: state_d.s1 = ST_EMPTY;
            endcase

            case (state_q.s2)
                ST_EMPTY: if (s2_load) state_d.s2 = ST_FULL;
                ST_FULL: begin
                    if (s2_load)        state_d.s2 = ST_FULL;
                    else if (out_ready) state_d.s2 = ST_EMPTY;
                end
                default: state_d.s2 = ST_EMPTY;
            endcase
        end

        if (s1_load) begin
            s1_p1_d  = in_p1;
            s1_tag_d = in_tag;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
            s1_mid_d = {1'b0, in_p2} + {1'b0, in_p3};
            s1_p4_d  = in_p4;
`else
            s1_mid_d = in_p2[15:0] + in_p3[15:0];
`endif
        end

        if (s2_load) begin
            out_tag_d = s1_tag_q;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
            out_result_d    = lo_sum[31:0];
            // The carry out of the low word feeds the high word.
            out_result_hi_d = s1_p4_q + {15'b0, s1_mid_q[32:16]} + {31'b0, lo_sum[32]};
`else
            // Product is taken mod 2^32; the carry out is not needed.
            out_result_d    = s1_p1_q + {s1_mid_q, 16'h0};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= '{s1: ST_EMPTY, s2: ST_EMPTY};
            s1_p1_q         <= '0;
            s1_mid_q        <= '0;
            s1_tag_q        <= '0;
            out_result_q    <= '0;
            out_tag_q       <= '0;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
            s1_p4_q         <= '0;
            out_result_hi_q <= '0;
`endif
        end else begin
            state_q         <= state_d;
            s1_p1_q         <= s1_p1_d;
            s1_mid_q        <= s1_mid_d;
            s1_tag_q        <= s1_tag_d;
            out_result_q    <= out_result_d;
            out_tag_q       <= out_tag_d;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
            s1_p4_q         <= s1_p4_d;
            out_result_hi_q <= out_result_hi_d;
`endif
        end
    end

    assign out_valid     = s2_valid;
    assign out_result    = out_result_q;
    assign out_tag       = out_tag_q;
`ifdef NIOS2_MUL_COMBINE_HIGH_EN
    assign out_result_hi = out_result_hi_q;
`endif

endmodule
